// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute controller for the 9-bit-instruction core.
// Owns the PC and instruction register and walks the datapath through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB, stopping in HALT on the HALT encoding.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  one-cycle pulse, (re)starts execution from START_PC when not busy
//   instr_in               instruction-memory read data for the current pc
//   branch_en/mem_rd/mem_wr decoder outputs for the instruction held in ir
//   mem_ack                data-memory completion strobe (only observed in MEM)
//   target_addr            branch target
//   pc, ir                 instruction address and latched instruction
//   mem_req, wb_en         data-memory request level, register-write qualifier
//   busy, done             running / halted status
//   retired                saturating count of retired instructions
//   timeout_err            sticky memory-ack watchdog flag
//
// Optional feature: define INSTR_SEQ_TIMEOUT_EN to build the memory-ack watchdog.
// Without it timeout_err is tied to 0 and MEM waits for mem_ack indefinitely.

module instr_sequencer #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned START_PC = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [8:0]      instr_in,
  input  logic            branch_en,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic            mem_ack,
  input  logic [PC_W-1:0] target_addr,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      ir,
  output logic            mem_req,
  output logic            wb_en,
  output logic            busy,
  output logic            done,
  output logic [15:0]     retired,
  output logic            timeout_err
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic            br_q, br_d;
  logic            mem_req_q, mem_req_d;
  logic            wb_en_q, wb_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            is_halt;

  assign is_halt = (ir_q[8:7] == 2'b00) && (ir_q[3:0] == 4'hF);

`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last waiting cycle before the count would reach TIMEOUT.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    br_d      = br_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d      = StartPc;
          retired_d = '0;
          state_d   = StFetch;
`ifdef INSTR_SEQ_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      StFetch: begin
        ir_d    = instr_in;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = is_halt ? StHalt : StExec;
      end
      StExec: begin
        br_d    = branch_en;
        state_d = (mem_rd || mem_wr) ? StMem : StWb;
`ifdef INSTR_SEQ_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StMem: begin
        // An ack always wins over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          state_d = StWb;
`ifdef INSTR_SEQ_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          state_d       = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StWb: begin
        pc_d      = br_q ? target_addr : pc_q + 1'b1;
        retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered images of the next state.
    mem_req_d = (state_d == StMem);
    wb_en_d   = (state_d == StWb);
    done_d    = (state_d == StHalt);
    busy_d    = (state_d != StIdle) && (state_d != StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= StartPc;
      ir_q      <= '0;
      retired_q <= '0;
      br_q      <= 1'b0;
      mem_req_q <= 1'b0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef INSTR_SEQ_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      br_q      <= br_d;
      mem_req_q <= mem_req_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef INSTR_SEQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;
  assign mem_req = mem_req_q;
  assign wb_en   = wb_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef INSTR_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random programs checked against
// an instruction-level reference model (expected cycle counts, pc and retired per instruction).

module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  instr_in;
  logic        branch_en;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic [9:0]  target_addr;
  logic [9:0]  pc;
  logic [8:0]  ir;
  logic        mem_req;
  logic        wb_en;
  logic        busy;
  logic        done;
  logic [15:0] retired;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0]  imem [1024];
  logic        br_mask;
  logic [9:0]  m_pc;
  logic [15:0] m_ret;

  instr_sequencer #(
    .PC_W     (10),
    .START_PC (0),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_in    (instr_in),
    .branch_en   (branch_en),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ack     (mem_ack),
    .target_addr (target_addr),
    .pc          (pc),
    .ir          (ir),
    .mem_req     (mem_req),
    .wb_en       (wb_en),
    .busy        (busy),
    .done        (done),
    .retired     (retired),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory and a toy decoder: class 01 with ir[0] branches,
  // class 10 loads, class 11 stores.
  always_comb begin
    instr_in  = imem[pc];
    branch_en = (ir[8:7] == 2'b01) && ir[0] && !br_mask;
    mem_rd    = (ir[8:7] == 2'b10);
    mem_wr    = (ir[8:7] == 2'b11);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start; returns at the negedge of the FETCH cycle.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc  = 10'd0;
    m_ret = 16'd0;
    check("start_pc", pc, 0);
    check("start_retired", retired, 0);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_terr", timeout_err, 0);
  endtask

  // Runs one instruction from its FETCH cycle. n_wait = MEM cycles before the ack cycle,
  // start_at = instruction cycle in which start is pulsed (0 = never).
  task automatic run_instr(input int n_wait, input int start_at, input logic [9:0] tgt,
                           output bit halted);
    logic [8:0] ins;
    bit hlt, is_mem, is_br, pc_bad;
    int cyc, reqs, wbs;
    ins    = imem[m_pc];
    hlt    = (ins[8:7] == 2'b00) && (ins[3:0] == 4'hF);
    is_mem = ins[8];
    is_br  = (ins[8:7] == 2'b01) && ins[0] && !br_mask;
    target_addr = tgt;
    cyc = 0; reqs = 0; wbs = 0; pc_bad = 0; halted = 0;
    for (int k = 0; k < 40; k++) begin
      cyc++;
      start = (cyc == start_at);
      if (mem_req) begin
        mem_ack = (reqs == n_wait);
        reqs++;
      end else begin
        mem_ack = 1'($urandom);
      end
      if (wb_en) wbs++;
      if (pc !== m_pc) pc_bad = 1;
      if (wb_en || done) break;
      @(negedge clk);
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    check("pc_stable", 32'(pc_bad), 0);
    check("timeout_err_low", timeout_err, 0);
    if (hlt) begin
      halted = 1;
      check("halt_cycles", cyc, 3);
      check("halt_done", done, 1);
      check("halt_busy", busy, 0);
      check("halt_wb", wbs, 0);
      check("halt_retired", retired, m_ret);
    end else begin
      check("instr_cycles", cyc, is_mem ? 5 + n_wait : 4);
      check("mem_req_cycles", reqs, is_mem ? n_wait + 1 : 0);
      check("wb_pulses", wbs, 1);
      m_pc  = is_br ? tgt : m_pc + 10'd1;
      m_ret = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
      @(negedge clk);
      check("next_pc", pc, m_pc);
      check("retired", retired, m_ret);
      check("wb_drop", wb_en, 0);
      check("fetch_busy", busy, 1);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 1024; i++) imem[i] = 9'h00F;
  endtask

  initial begin
    bit h;
    int reqs, wbs;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; target_addr = '0; br_mask = 1'b0;
    m_pc = '0; m_ret = '0;
    fill_halt();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_retired", retired, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // ADD then HALT
    imem[0] = 9'h003;
    do_start();
    run_instr(0, 0, 10'h155, h);
    run_instr(0, 0, 10'h155, h);
    check("add_halted", 32'(h), 1);
    check("add_final_pc", pc, 1);
    check("add_final_ret", retired, 1);

    // Load with three wait cycles, start issued from HALT
    fill_halt();
    imem[0] = 9'h100;
    do_start();
    run_instr(3, 0, 10'h000, h);
    run_instr(0, 0, 10'h000, h);
    check("load_halted", 32'(h), 1);

    // Branch taken, not taken, to 3FF, then wrap
    fill_halt();
    imem[0] = 9'h081; imem[10'h2A] = 9'h081; imem[10'h2B] = 9'h081; imem[10'h3FF] = 9'h003;
    do_start();
    run_instr(0, 0, 10'h2A, h);
    check("branch_pc", pc, 10'h2A);
    br_mask = 1'b1;
    run_instr(0, 0, 10'h2A, h);
    check("nobranch_pc", pc, 10'h2B);
    br_mask = 1'b0;
    imem[0] = 9'h00F;
    run_instr(0, 0, 10'h3FF, h);
    run_instr(0, 0, 10'h123, h);
    check("wrap_pc", pc, 0);
    run_instr(0, 0, 10'h000, h);
    check("wrap_halted", 32'(h), 1);

    // Reset during MEM
    fill_halt();
    imem[0] = 9'h003; imem[1] = 9'h180;
    do_start();
    run_instr(0, 0, 10'h000, h);
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_busy", busy, 0);
    check("async_wb_en", wb_en, 0);
    check("async_pc", pc, 0);
    check("async_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_pc", pc, 0);
    imem[1] = 9'h00F;
    do_start();
    run_instr(0, 0, 10'h000, h);
    run_instr(0, 0, 10'h000, h);
    check("post_rst_halted", 32'(h), 1);

    // start during EXEC is ignored
    fill_halt();
    imem[0] = 9'h003;
    do_start();
    run_instr(0, 3, 10'h000, h);
    run_instr(0, 0, 10'h000, h);
    check("exec_start_halted", 32'(h), 1);

`ifdef INSTR_SEQ_TIMEOUT_EN
    // No ack: watchdog expires after four MEM cycles
    fill_halt();
    imem[0] = 9'h100;
    do_start();
    reqs = 0; wbs = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      mem_ack = 1'b0;
      if (mem_req) reqs++;
      if (wb_en) wbs++;
      @(negedge clk);
    end
    check("to_mem_cycles", reqs, 4);
    check("to_wb", wbs, 0);
    check("to_done", done, 1);
    check("to_err", timeout_err, 1);
    check("to_pc", pc, 0);
    check("to_retired", retired, 0);
    // Ack on the fourth wait cycle wins
    do_start();
    run_instr(3, 0, 10'h000, h);
    run_instr(0, 0, 10'h000, h);
    check("to_ack_halted", 32'(h), 1);
`endif

    // Random programs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1024; i++) imem[i] = 9'($urandom);
      imem[0] = 9'h003;
      do_start();
      for (int n = 0; n < 25; n++) begin
        run_instr($urandom_range(0, 3), 0, 10'($urandom), h);
        if (h) break;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
